front_panel_ctrl: RTL and testbench

Parametrised operator front panel for the multicycle processor. It synchronises and debounces the RUN, CLR, A_M and MAN_CLK panel switches and drives a single-cycle clock-enable (`clk_en`) into the core, replacing direct clock muxing. Auto mode uses a programmable prescaler; manual mode produces one enable per MAN_CLK press. It adds processor halt handling, stretched PC reset and a halt indicator.

---
 rtl/front_panel_pkg.sv | 19 +
 rtl/pb_debounce.sv | 47 ++++
 rtl/front_panel_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_front_panel_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/front_panel_pkg.sv
// rtl/front_panel_pkg.sv - shared types, constants and width helpers for the front panel controller
package front_panel_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_AUTO = 3'd1,
        RUN_MAN  = 3'd2,
        CLEAR    = 3'd3,
        HALTED   = 3'd4
    } fsm_state_t;

    localparam int SYNC_STAGES = 2;

    // Bits needed for a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - two-flop synchroniser followed by a stable-sample debounce counter
module pb_debounce
    import front_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // The output flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            dout   <= 1'b0;
        end else if (sample != dout) begin
            if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                dout   <= sample;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

endmodule

// File: rtl/front_panel_ctrl.sv
// rtl/front_panel_ctrl.sv - operator front panel clock-enable FSM; optional FRONT_PANEL_CYCLE_CNT_EN cycle counter
module front_panel_ctrl
    import front_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_DIV        = 3,
    parameter int RST_STRETCH     = 2
`ifdef FRONT_PANEL_CYCLE_CNT_EN
    ,
    parameter int CNT_W           = 16
`endif
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             RUN,
    input  logic             CLR,
    input  logic             A_M,
    input  logic             MAN_CLK,
    input  logic             halt_req,
    output logic             clk_en,
    output logic             run_ind,
    output logic             clr_ind,
    output logic             a_m_ind,
    output logic             halt_ind,
    output logic             pc_rst
`ifdef FRONT_PANEL_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_count
`endif
);

    localparam int PRESC_W   = cnt_w(AUTO_DIV);
    localparam int STRETCH_W = cnt_w(RST_STRETCH);
    localparam logic [PRESC_W-1:0]   PRESC_LAST   = PRESC_W'(AUTO_DIV - 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'((RST_STRETCH > 0) ? RST_STRETCH - 1 : 0);

    logic run_db;
    logic clr_db;
    logic a_m_db;
    logic man_db;

    fsm_state_t state;
    fsm_state_t next_state;
    fsm_state_t run_target;

    logic [PRESC_W-1:0]   presc;
    logic [STRETCH_W-1:0] stretch_cnt;
    logic                 stretch_done;
    logic                 man_prev;
    logic                 man_rise;
    logic                 clk_en_d;

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clock (clock),
        .rst_n (rst_n),
        .din   (RUN),
        .dout  (run_db)
    );

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clock (clock),
        .rst_n (rst_n),
        .din   (CLR),
        .dout  (clr_db)
    );

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a_m_db (
        .clock (clock),
        .rst_n (rst_n),
        .din   (A_M),
        .dout  (a_m_db)
    );

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_man_db (
        .clock (clock),
        .rst_n (rst_n),
        .din   (MAN_CLK),
        .dout  (man_db)
    );

    // Edge detector runs in every state so a press held before RUN_MAN never fires.
    assign man_rise = man_db & ~man_prev;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            man_prev <= 1'b0;
        end else begin
            state    <= next_state;
            man_prev <= man_db;
        end
    end

    always_comb begin
        next_state   = state;
        stretch_done = (stretch_cnt == STRETCH_LAST);
        if (!run_db) begin
            run_target = IDLE;
        end else if (a_m_db) begin
            run_target = RUN_MAN;
        end else begin
            run_target = RUN_AUTO;
        end

        if (clr_db) begin
            next_state = CLEAR;
        end else begin
            case (state)
                CLEAR: begin
                    if (stretch_done) begin
                        next_state = run_target;
                    end
                end
                RUN_AUTO, RUN_MAN: begin
                    if (halt_req) begin
                        next_state = HALTED;
                    end else begin
                        next_state = run_target;
                    end
                end
                HALTED: begin
                    if (!run_db) begin
                        next_state = IDLE;
                    end
                end
                IDLE: begin
                    if (run_db) begin
                        next_state = run_target;
                    end
                end
                default: next_state = IDLE;
            endcase
        end

        // A pulse is only issued when the run state is retained across the edge.
        clk_en_d = 1'b0;
        if ((state == RUN_AUTO) && (next_state == RUN_AUTO) && (presc == PRESC_LAST)) begin
            clk_en_d = 1'b1;
        end
        if ((state == RUN_MAN) && (next_state == RUN_MAN) && man_rise) begin
            clk_en_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if ((state == RUN_AUTO) && (next_state == RUN_AUTO)) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end else begin
            presc <= '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stretch_cnt <= '0;
        end else if ((state == CLEAR) && !clr_db && !stretch_done) begin
            stretch_cnt <= stretch_cnt + 1'b1;
        end else begin
            stretch_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            clk_en   <= 1'b0;
            run_ind  <= 1'b0;
            clr_ind  <= 1'b0;
            a_m_ind  <= 1'b0;
            halt_ind <= 1'b0;
            pc_rst   <= 1'b0;
        end else begin
            clk_en   <= clk_en_d;
            run_ind  <= (next_state == RUN_AUTO) || (next_state == RUN_MAN);
            clr_ind  <= (next_state == CLEAR);
            a_m_ind  <= ~a_m_db;
            halt_ind <= (next_state == HALTED);
            pc_rst   <= (next_state == CLEAR);
        end
    end

`ifdef FRONT_PANEL_CYCLE_CNT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (next_state == CLEAR) begin
            cycle_count <= '0;
        end else if (clk_en) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_front_panel_ctrl.sv
// tb/tb_front_panel_ctrl.sv - directed self-checking bench for front_panel_ctrl
module tb_front_panel_ctrl;

    logic clock = 1'b0;
    logic rst_n;
    logic RUN;
    logic CLR;
    logic A_M;
    logic MAN_CLK;
    logic halt_req;
    logic clk_en;
    logic run_ind;
    logic clr_ind;
    logic a_m_ind;
    logic halt_ind;
    logic pc_rst;
`ifdef FRONT_PANEL_CYCLE_CNT_EN
    logic [15:0] cycle_count;
`endif

    logic [5:0] outs;
    assign outs = {clk_en, run_ind, clr_ind, a_m_ind, halt_ind, pc_rst};

    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    front_panel_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_DIV        (3),
        .RST_STRETCH     (2)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .RUN         (RUN),
        .CLR         (CLR),
        .A_M         (A_M),
        .MAN_CLK     (MAN_CLK),
        .halt_req    (halt_req),
        .clk_en      (clk_en),
        .run_ind     (run_ind),
        .clr_ind     (clr_ind),
        .a_m_ind     (a_m_ind),
        .halt_ind    (halt_ind),
        .pc_rst      (pc_rst)
`ifdef FRONT_PANEL_CYCLE_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        RUN = 0; CLR = 0; A_M = 0; MAN_CLK = 0; halt_req = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        vecs++;
        if (outs !== 6'b000000) begin errs++; $display("FAIL reset_outs: got %b expected %b", outs, 6'b000000); end
        @(posedge clock); #1;
        rst_n = 1'b1;
        step(1);
        vecs++;
        if (outs !== 6'b000100) begin errs++; $display("FAIL reset_idle: got %b expected %b", outs, 6'b000100); end
        step(8);
    endtask

    task automatic test_auto;
        int pulses, last, bad_gap;
        RUN = 1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 6) begin
                vecs++;
                if (outs !== 6'b000100) begin errs++; $display("FAIL auto_pre_edge: got %b expected %b", outs, 6'b000100); end
            end
            if (k == 7) begin
                vecs++;
                if (outs !== 6'b010100) begin errs++; $display("FAIL auto_run_ind: got %b expected %b", outs, 6'b010100); end
            end
        end
        pulses = 0; last = 0; bad_gap = 0;
        for (int j = 1; j <= 30; j++) begin
            step(1);
            if (clk_en) begin
                pulses++;
                if ((last == 0) ? (j != 3) : (j - last != 3)) bad_gap++;
                last = j;
            end
        end
        vecs++;
        if (pulses !== 10) begin errs++; $display("FAIL auto_pulse_count: got %0d expected %0d", pulses, 10); end
        vecs++;
        if (bad_gap !== 0) begin errs++; $display("FAIL auto_spacing: got %0d bad gaps expected %0d", bad_gap, 0); end
        RUN = 0;
        step(7);
        vecs++;
        if (outs !== 6'b000100) begin errs++; $display("FAIL auto_stop: got %b expected %b", outs, 6'b000100); end
    endtask

    task automatic test_glitch;
        logic run_seen, en_seen;
        run_seen = 0; en_seen = 0;
        for (int c = 0; c < 30; c++) begin
            RUN = (c < 10) && ((c / 2) % 2 == 0);
            step(1);
            run_seen |= run_ind;
            en_seen  |= clk_en;
        end
        vecs++;
        if (run_seen !== 1'b0) begin errs++; $display("FAIL glitch_run_ind: got %b expected %b", run_seen, 1'b0); end
        vecs++;
        if (en_seen !== 1'b0) begin errs++; $display("FAIL glitch_clk_en: got %b expected %b", en_seen, 1'b0); end
    endtask

    task automatic test_clear;
        logic [5:0] got, exp;
        logic e_en, e_run, e_clr;
        RUN = 1;
        step(7);
        vecs++;
        if (outs !== 6'b010100) begin errs++; $display("FAIL clear_setup: got %b expected %b", outs, 6'b010100); end
        step(5);
        CLR = 1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            e_clr = (k >= 7) && (k <= 17);
            e_run = (k <= 6) || (k >= 18);
            e_en  = (k == 21) || (k == 24);
            got = outs;
            exp = {e_en, e_run, e_clr, 1'b1, 1'b0, e_clr};
            if (k <= 6) begin
                got[5] = 1'b0;
                exp[5] = 1'b0;
            end
            vecs++;
            if (got !== exp) begin errs++; $display("FAIL clear_k%0d: got %b expected %b", k, got, exp); end
            if (k == 10) CLR = 0;
        end
    endtask

    task automatic test_halt;
        logic en_seen, halt_lost;
        step(2);
        halt_req = 1;
        step(1);
        halt_req = 0;
        vecs++;
        if (outs !== 6'b000110) begin errs++; $display("FAIL halt_enter: got %b expected %b", outs, 6'b000110); end
        en_seen = 0; halt_lost = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            en_seen   |= clk_en;
            halt_lost |= ~halt_ind;
        end
        vecs++;
        if ({en_seen, halt_lost} !== 2'b00) begin errs++; $display("FAIL halt_hold: got %b expected %b", {en_seen, halt_lost}, 2'b00); end
        RUN = 0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 6) begin
                vecs++;
                if (outs !== 6'b000110) begin errs++; $display("FAIL halt_pre_idle: got %b expected %b", outs, 6'b000110); end
            end
            if (k == 7) begin
                vecs++;
                if (outs !== 6'b000100) begin errs++; $display("FAIL halt_to_idle: got %b expected %b", outs, 6'b000100); end
            end
        end
        step(3);
        RUN = 1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k >= 7) begin
                vecs++;
                if (outs !== ((k == 10) ? 6'b110100 : 6'b010100)) begin
                    errs++;
                    $display("FAIL halt_restart_k%0d: got %b expected %b", k, outs, (k == 10) ? 6'b110100 : 6'b010100);
                end
            end
        end
    endtask

    task automatic test_manual;
        int pv[12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        int pl[12] = '{8, 8, 8, 8, 8, 8, 2, 2, 2, 2, 8, 8};
        int pulses, dbl;
        logic prev;
        RUN = 0;
        step(10);
        A_M = 1;
        RUN = 1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 7) begin
                vecs++;
                if (outs !== 6'b010000) begin errs++; $display("FAIL man_enter: got %b expected %b", outs, 6'b010000); end
            end
        end
        step(3);
        pulses = 0; dbl = 0; prev = 0;
        for (int i = 0; i < 12; i++) begin
            MAN_CLK = pv[i][0];
            for (int c = 0; c < pl[i]; c++) begin
                step(1);
                if (clk_en) begin
                    pulses++;
                    if (prev) dbl++;
                end
                prev = clk_en;
            end
        end
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (clk_en) begin
                pulses++;
                if (prev) dbl++;
            end
            prev = clk_en;
        end
        vecs++;
        if (pulses !== 4) begin errs++; $display("FAIL man_pulse_count: got %0d expected %0d", pulses, 4); end
        vecs++;
        if (dbl !== 0) begin errs++; $display("FAIL man_single_cycle: got %0d expected %0d", dbl, 0); end
    endtask

    task automatic test_reset_mid_run;
        vecs++;
        if (outs !== 6'b010000) begin errs++; $display("FAIL rst_mid_setup: got %b expected %b", outs, 6'b010000); end
        #3 rst_n = 1'b0;
        #1;
        vecs++;
        if (outs !== 6'b000000) begin errs++; $display("FAIL rst_mid_async: got %b expected %b", outs, 6'b000000); end
        @(posedge clock); #1;
        vecs++;
        if (outs !== 6'b000000) begin errs++; $display("FAIL rst_mid_held: got %b expected %b", outs, 6'b000000); end
        #2 rst_n = 1'b1;
        step(1);
        vecs++;
        if (outs !== 6'b000100) begin errs++; $display("FAIL rst_mid_idle: got %b expected %b", outs, 6'b000100); end
    endtask

    initial begin
        test_reset;
        test_auto;
        test_glitch;
        test_clear;
        test_halt;
        test_manual;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
